led_seq_ctrl: RTL
=================

Name: led_seq_ctrl

Overview:
- Command-driven controller for a single board LED.
- Sequences an internal period counter (prescaler plus toggle) to produce steady-off, steady-on, continuous-blink or counted-burst patterns.
- Sits between top-level control logic (switches/keys, later the calculator FSM) and an LEDR output.
- Replaces free-running per-LED blinkers, which have a fixed rate.

Parameters:
- CNT_W, 32, width of half-period counter and cmd_half.
- REP_W, 8, width of burst repeat count.
- RESET_HALF, 50_000_000, half-period loaded at reset (1 s at 50 MHz).

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cmd_half  in  CNT_W  half-period in clk cycles; 0 treated as 1.
- cmd_reps  in  REP_W  BURST high-pulse count.
- led  out  1  registered LED drive, 1=lit.
- busy  out  1  high while a BURST runs.
- done  out  1  one-cycle pulse at BURST completion.

Behaviour:
- Single clock domain; reset is synchronous and active-high. Clock is clk, reset is rst.
- Reset (any time, including mid-burst):
  - State ST_STEADY, led=0, busy=0, done=0, cnt=0.
  - Stored half=RESET_HALF, reps_left=0.
  - Any pending command is discarded.
- Accept on cmd_valid && cmd_ready. Accepted in cycle N means the new led value is visible in cycle N+1.
- Effective half H = max(cmd_half, 1), latched at accept.
- cnt restarts at 0 on every accept. Each phase lasts exactly H cycles: cnt counts 0..H-1, the phase ends at cnt==H-1, then cnt returns to 0.
- States:
  - ST_STEADY: led holds 0 (OFF) or 1 (ON); cnt idle. cmd_ready=1.
  - ST_BLINK: led=1 for H cycles, then 0 for H cycles, repeating forever. cmd_ready=1, so any new command preempts immediately.
  - ST_BURST_HI: led=1 for H cycles, then reps_left decrements.
    - reps_left becomes 0: go to ST_STEADY with led=0, and assert done in the same cycle led falls.
    - Otherwise go to ST_BURST_LO.
  - ST_BURST_LO: led=0 for H cycles, then go to ST_BURST_HI.
- BURST accept:
  - reps=0: no pulses. Go to ST_STEADY with led=0 and pulse done in cycle N+1.
  - reps>0: enter ST_BURST_HI and raise busy in cycle N+1. busy drops in the cycle done pulses.
- During ST_BURST_HI/LO, cmd_ready=0 (base build). Bursts are never truncated except by rst.
- Command sequence per mode:
  - OFF: ST_STEADY, led=0.
  - ON: ST_STEADY, led=1.
  - BLINK: ST_BLINK, led=1.
- Counter arithmetic: unsigned CNT_W, compare-equal only. H = 2^CNT_W-1 is legal. No wrap beyond H-1.
- done is never asserted outside BURST completion.

Optional Feature:
- Macro: LED_SEQ_CMD_BUF_EN.
- Defined:
  - Adds a one-entry pending-command register.
  - During a burst, cmd_ready = pending empty. A command accepted mid-burst is stored.
  - At burst completion (the done cycle), the pending command is applied as if accepted that cycle, so its led value appears next cycle; pending then clears.
  - In non-burst states, commands bypass the buffer as in the base build.
  - rst clears pending.
- Undefined: behaviour exactly as the base build; no pending register.

Decomposition:
- Shared package led_seq_pkg:
  - mode encodings MODE_OFF/ON/BLINK/BURST.
  - state encodings ST_STEADY/BLINK/BURST_HI/BURST_LO.
  - RESET_HALF default constant.
- One sub-module: led_seq_period. Holds the half-period counter with inputs restart and half, and output phase_end, asserted at cnt==H-1.
- Controller FSM, repeat counter and command buffer stay in led_seq_ctrl.

Test Plan:
- Reset then idle 10 cycles -> led=0, busy=0, done=0, cmd_ready=1 every cycle.
- BLINK, half=3, accepted cycle 0 -> led=1 in cycles 1-3, 0 in 4-6, 1 in 7-9; then OFF mid-phase -> led=0 next cycle.
- BURST, half=2, reps=3 -> led pattern 1,1,0,0,1,1,0,0,1,1,0 with done high only in the final 0 cycle (cycle 11); busy high cycles 1-10; cmd_ready=0 cycles 1-10.
- BURST reps=0 and BLINK half=0 -> done pulse cycle 1 with led=0; BLINK half=0 toggles led every cycle.
- rst asserted in ST_BURST_LO -> next cycle led=0, busy=0, done=0, state ST_STEADY, no done pulse afterwards.
- With LED_SEQ_CMD_BUF_EN: ON offered during BURST half=2, reps=2 -> accepted, cmd_ready drops; led goes 1 in the cycle after done. Second command offered is held off (cmd_ready=0) until done.

Source files
------------

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode/state encodings and reset constants for the LED sequencer
package led_seq_pkg;

    localparam int unsigned RESET_HALF_DEF = 50_000_000;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_STEADY   = 2'd0,
        ST_BLINK    = 2'd1,
        ST_BURST_HI = 2'd2,
        ST_BURST_LO = 2'd3
    } state_t;

    function automatic logic is_burst(input state_t s);
        return (s == ST_BURST_HI) || (s == ST_BURST_LO);
    endfunction

endpackage

// File: rtl/led_seq_if.sv
// rtl/led_seq_if.sv - command handshake bundle between control logic and the LED sequencer
interface led_seq_if #(
    parameter int CNT_W = 32,
    parameter int REP_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_half;
    logic [REP_W-1:0] cmd_reps;

    modport master (
        output cmd_valid, cmd_mode, cmd_half, cmd_reps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_half, cmd_reps,
        output cmd_ready
    );
endinterface

// File: rtl/led_seq_period.sv
// rtl/led_seq_period.sv - half-period counter; phase_end flags the last cycle of each phase
module led_seq_period #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic [CNT_W-1:0] half,
    output logic             phase_end
);
    logic [CNT_W-1:0] cnt;

    // half is never 0, so half-1 cannot underflow and cnt never exceeds H-1
    assign phase_end = en && (cnt == half - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || restart || !en) begin
            cnt <= '0;
        end else if (phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - command-driven LED pattern controller (optional LED_SEQ_CMD_BUF_EN pending-command buffer)
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter int          REP_W      = 8,
    parameter int unsigned RESET_HALF = RESET_HALF_DEF
) (
    input  logic      clk,
    input  logic      rst,
    led_seq_if.slave  cmd,
    output logic      led,
    output logic      busy,
    output logic      done
);
    state_t           state;
    logic [CNT_W-1:0] half_q;
    logic [REP_W-1:0] reps_left;
    logic             phase_end;
    logic             in_burst;
    logic             acc;

    logic             app_go;
    logic [1:0]       app_mode;
    logic [CNT_W-1:0] app_half;
    logic [REP_W-1:0] app_reps;

    assign in_burst = is_burst(state);
    assign acc      = cmd.cmd_valid && cmd.cmd_ready;

`ifdef LED_SEQ_CMD_BUF_EN
    logic             pend_v;
    logic [1:0]       pend_mode;
    logic [CNT_W-1:0] pend_half;
    logic [REP_W-1:0] pend_reps;

    // pend_v is only set during a burst and through its done cycle
    assign cmd.cmd_ready = !pend_v;

    always_comb begin
        app_go   = 1'b0;
        app_mode = cmd.cmd_mode;
        app_half = cmd.cmd_half;
        app_reps = cmd.cmd_reps;
        if (done && pend_v) begin
            app_go   = 1'b1;
            app_mode = pend_mode;
            app_half = pend_half;
            app_reps = pend_reps;
        end else if (acc && !in_burst) begin
            app_go = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v    <= 1'b0;
            pend_mode <= '0;
            pend_half <= '0;
            pend_reps <= '0;
        end else if (acc && in_burst) begin
            pend_v    <= 1'b1;
            pend_mode <= cmd.cmd_mode;
            pend_half <= cmd.cmd_half;
            pend_reps <= cmd.cmd_reps;
        end else if (done && pend_v) begin
            pend_v <= 1'b0;
        end
    end
`else
    assign cmd.cmd_ready = !in_burst;

    always_comb begin
        app_go   = acc;
        app_mode = cmd.cmd_mode;
        app_half = cmd.cmd_half;
        app_reps = cmd.cmd_reps;
    end
`endif

    led_seq_period #(.CNT_W(CNT_W)) u_period (
        .clk       (clk),
        .rst       (rst),
        .en        (state != ST_STEADY),
        .restart   (app_go),
        .half      (half_q),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_STEADY;
            led       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            half_q    <= CNT_W'(RESET_HALF);
            reps_left <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_BLINK: begin
                    if (phase_end) led <= ~led;
                end
                ST_BURST_HI: begin
                    if (phase_end) begin
                        led       <= 1'b0;
                        reps_left <= reps_left - REP_W'(1);
                        if (reps_left == REP_W'(1)) begin
                            state <= ST_STEADY;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_BURST_LO;
                        end
                    end
                end
                ST_BURST_LO: begin
                    if (phase_end) begin
                        state <= ST_BURST_HI;
                        led   <= 1'b1;
                    end
                end
                default: ;
            endcase

            // An applied command overrides whatever the running pattern did this cycle
            if (app_go) begin
                half_q <= (app_half == '0) ? CNT_W'(1) : app_half;
                case (mode_t'(app_mode))
                    MODE_OFF: begin
                        state <= ST_STEADY;
                        led   <= 1'b0;
                        busy  <= 1'b0;
                    end
                    MODE_ON: begin
                        state <= ST_STEADY;
                        led   <= 1'b1;
                        busy  <= 1'b0;
                    end
                    MODE_BLINK: begin
                        state <= ST_BLINK;
                        led   <= 1'b1;
                        busy  <= 1'b0;
                    end
                    MODE_BURST: begin
                        reps_left <= app_reps;
                        if (app_reps == '0) begin
                            state <= ST_STEADY;
                            led   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_BURST_HI;
                            led   <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule
